serial_add_ctrl: RTL and testbench

Bit-serial adder controller that sequences one shared full-adder slice, built from two half-adder cells, across the bits of a WIDTH-bit operand pair. Operands enter over a valid/ready handshake. The block iterates LSB-first, one bit per clock, and presents the sum and carry-out over a second valid/ready handshake. It sits between any requester needing a multi-bit add and the single-bit adder datapath, trading latency for area.

---
 rtl/serial_add_pkg.sv | 27 ++
 rtl/half_adder_cell.sv | 22 ++
 rtl/serial_add_ctrl.sv | 153 +++++++++++++++
 tb/tb_serial_add_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial adder controller: the controller state
// encoding, the legal operand width range, and a helper that sizes the bit
// counter from the operand width.
// -----------------------------------------------------------------------------
package serial_add_pkg;

  // Legal operand widths for serial_add_ctrl
  localparam int unsigned WIDTH_MIN     = 1;
  localparam int unsigned WIDTH_MAX     = 64;
  localparam int unsigned WIDTH_DEFAULT = 8;

  // Controller states; the encoding is fixed so it can be probed in the lab
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Bit counter width: enough to hold WIDTH-1, but never narrower than one bit
  // so a single-bit adder still has a well-formed counter.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/half_adder_cell.sv
// -----------------------------------------------------------------------------
// half_adder_cell
// One half-adder bit cell. Two of these plus an OR gate form the full-adder
// slice that serial_add_ctrl reuses for every bit position.
//
// Ports:
//   x  in   first addend bit
//   y  in   second addend bit
//   s  out  sum bit   (x ^ y)
//   c  out  carry bit (x & y)
// -----------------------------------------------------------------------------
module half_adder_cell (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder controller. Accepts a WIDTH-bit operand pair over a
// valid/ready handshake, walks the pair LSB-first through one shared full-adder
// slice (two half_adder_cell instances), one bit per clock, and offers the sum
// and carry-out over a second valid/ready handshake.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands a/b valid
//   in_ready   out  operands can be accepted (IDLE only)
//   a, b       in   WIDTH-bit operands, sampled on acceptance only
//   abort      in   synchronous cancel, honoured only while running
//   out_valid  out  sum/carry_out valid (DONE only)
//   out_ready  in   consumer takes the result
//   sum        out  (a + b) mod 2^WIDTH
//   carry_out  out  bit WIDTH of a + b
//   busy       out  high while bits are being processed
// -----------------------------------------------------------------------------
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int unsigned      CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic [WIDTH-1:0]   opA_q;
  logic [WIDTH-1:0]   opB_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;

  logic               s0;
  logic               c0;
  logic               s1;
  logic               c1;
  logic               carry_d;
  logic [WIDTH-1:0]   acc_d;

  // Full-adder slice: the first cell adds the two operand LSBs, the second
  // folds in the carry left over from the previous bit.
  half_adder_cell u_ha0 (
    .x (opA_q[0]),
    .y (opB_q[0]),
    .s (s0),
    .c (c0)
  );

  half_adder_cell u_ha1 (
    .x (s0),
    .y (carry_q),
    .s (s1),
    .c (c1)
  );

  // At most one of the two half-adder carries can be set, so OR is enough.
  assign carry_d = c0 | c1;

  // The new sum bit enters at the MSB; after WIDTH shifts the first bit
  // processed has travelled down to bit 0.
  generate
    if (WIDTH == 1) begin : g_acc_single
      assign acc_d = s1;
    end else begin : g_acc_multi
      assign acc_d = {s1, acc_q[WIDTH-1:1]};
    end
  endgenerate

  // Controller, counter and shift registers. The working accumulator is kept
  // apart from the presented sum so that sum/carry_out only change when a
  // complete result lands and stay put through the following operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      opA_q   <= '0;
      opB_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            opA_q   <= a;
            opB_q   <= b;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end

        RUN: begin
          // abort takes priority even over the final bit
          if (abort) begin
            state_q <= IDLE;
          end else begin
            opA_q   <= opA_q >> 1;
            opB_q   <= opB_q >> 1;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_q + CNT_ONE;
            if (cnt_q == LAST_BIT) begin
              sum_q   <= acc_d;
              cout_q  <= carry_d;
              state_q <= DONE;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Handshake flags decode straight from state, so neither in_valid nor
  // out_ready has a combinational path to any output.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Bench for serial_add_ctrl. An 8-bit instance is driven by directed scenarios
// and then random traffic, and checked every cycle against a behavioural model
// that tracks the operation as "cycles of work left" plus plain integer
// addition. A 1-bit instance covers the single-cycle RUN case.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         busy;

  logic         in_valid1;
  logic         in_ready1;
  logic [0:0]   a1;
  logic [0:0]   b1;
  logic         abort1;
  logic         out_valid1;
  logic         out_ready1;
  logic [0:0]   sum1;
  logic         carry_out1;
  logic         busy1;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state
  int           busyLeft = 0;
  logic         doneFlag = 1'b0;
  logic [W-1:0] opA      = '0;
  logic [W-1:0] opB      = '0;
  logic [W-1:0] expSum   = '0;
  logic         expCout  = 1'b0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .abort     (abort1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .carry_out (carry_out1),
    .busy      (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison in the bench goes through here
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Present an operand pair and let the next edge take it; waits for IDLE first
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic keepValid);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      stepCycle();
      guard++;
    end
    checkOutput("accept_wait_bound", 64'(guard < 50), 64'd1);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    stepCycle();
    if (!keepValid) in_valid = 1'b0;
  endtask

  task automatic waitValid(input string name);
    int n = 0;
    while (!out_valid && n < 50) begin
      stepCycle();
      n++;
    end
    checkOutput(name, 64'(n < 50), 64'd1);
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    stepCycle();
    out_ready = 1'b0;
  endtask

  // Model: an accepted pair keeps the block busy for W edges, then the
  // arithmetic result appears and waits for the consumer. abort while busy
  // throws the work away; reset clears everything.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busyLeft = 0;
      doneFlag = 1'b0;
      expSum   = '0;
      expCout  = 1'b0;
    end else if (busyLeft > 0) begin
      if (abort) begin
        busyLeft = 0;
      end else begin
        busyLeft = busyLeft - 1;
        if (busyLeft == 0) begin
          {expCout, expSum} = {1'b0, opA} + {1'b0, opB};
          doneFlag = 1'b1;
        end
      end
    end else if (doneFlag) begin
      if (out_ready) doneFlag = 1'b0;
    end else if (in_valid) begin
      opA      = a;
      opB      = b;
      busyLeft = W;
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    checkOutput("in_ready",  64'(in_ready),  64'(busyLeft == 0 && !doneFlag));
    checkOutput("busy",      64'(busy),      64'(busyLeft > 0));
    checkOutput("out_valid", 64'(out_valid), 64'(doneFlag));
    checkOutput("sum",       64'(sum),       64'(expSum));
    checkOutput("carry_out", 64'(carry_out), 64'(expCout));
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  n;
    logic sawValid;

    rst_n      = 1'b1;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    abort      = 1'b0;
    out_ready  = 1'b0;
    in_valid1  = 1'b0;
    a1         = '0;
    b1         = '0;
    abort1     = 1'b0;
    out_ready1 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_in_ready",  64'(in_ready),  64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_busy",      64'(busy),      64'd0);
    checkOutput("rst_sum",       64'(sum),       64'd0);
    checkOutput("rst_carry",     64'(carry_out), 64'd0);
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    stepCycle();

    // 0x5A + 0x3C: latency from acceptance to valid is exactly W
    applyStimulus(8'h5A, 8'h3C, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      stepCycle();
      n++;
    end
    checkOutput("t1_latency", 64'(n), 64'd8);
    checkOutput("t1_sum",     64'(sum), 64'h96);
    checkOutput("t1_carry",   64'(carry_out), 64'd0);
    handoff();
    checkOutput("t1_ready_after", 64'(in_ready),  64'd1);
    checkOutput("t1_valid_after", 64'(out_valid), 64'd0);

    // 0xFF + 0x01: busy lasts exactly W cycles
    applyStimulus(8'hFF, 8'h01, 1'b0);
    n = 0;
    while (busy && n < 20) begin
      stepCycle();
      n++;
    end
    checkOutput("t2_busy_cycles", 64'(n), 64'd8);
    checkOutput("t2_sum",   64'(sum),       64'h00);
    checkOutput("t2_carry", 64'(carry_out), 64'd1);
    handoff();

    // 0x80 + 0x80 with the consumer stalling for 5 cycles
    applyStimulus(8'h80, 8'h80, 1'b0);
    waitValid("t3_valid_bound");
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3_hold_valid", 64'(out_valid), 64'd1);
      checkOutput("t3_hold_sum",   64'(sum),       64'h00);
      checkOutput("t3_hold_carry", 64'(carry_out), 64'd1);
      stepCycle();
    end
    handoff();
    checkOutput("t3_idle_valid", 64'(out_valid), 64'd0);
    checkOutput("t3_idle_ready", 64'(in_ready),  64'd1);
    checkOutput("t3_kept_carry", 64'(carry_out), 64'd1);

    // abort on the 4th RUN cycle of 0x12 + 0x34
    applyStimulus(8'h12, 8'h34, 1'b0);
    stepCycle();
    stepCycle();
    stepCycle();
    abort = 1'b1;
    stepCycle();
    abort = 1'b0;
    checkOutput("t4_abort_ready", 64'(in_ready), 64'd1);
    checkOutput("t4_abort_busy",  64'(busy),     64'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      stepCycle();
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("t4_no_valid", 64'(sawValid), 64'd0);
    applyStimulus(8'h01, 8'h02, 1'b0);
    waitValid("t4_valid_bound");
    checkOutput("t4_sum",   64'(sum),       64'h03);
    checkOutput("t4_carry", 64'(carry_out), 64'd0);
    handoff();

    // reset mid-RUN while in_valid stays high
    applyStimulus(8'h77, 8'h11, 1'b1);
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("t5_run_ready", 64'(in_ready), 64'd0);
    checkOutput("t5_run_busy",  64'(busy),     64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_ready", 64'(in_ready),  64'd1);
    checkOutput("t5_rst_busy",  64'(busy),      64'd0);
    checkOutput("t5_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("t5_rst_sum",   64'(sum),       64'd0);
    checkOutput("t5_rst_carry", 64'(carry_out), 64'd0);
    in_valid = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    stepCycle();

    // single-bit instance: 1 + 1
    checkOutput("w1_idle_ready", 64'(in_ready1), 64'd1);
    a1        = 1'b1;
    b1        = 1'b1;
    in_valid1 = 1'b1;
    stepCycle();
    in_valid1 = 1'b0;
    checkOutput("w1_busy",       64'(busy1),      64'd1);
    checkOutput("w1_not_valid",  64'(out_valid1), 64'd0);
    stepCycle();
    checkOutput("w1_valid",      64'(out_valid1), 64'd1);
    checkOutput("w1_sum",        64'(sum1),       64'd0);
    checkOutput("w1_carry",      64'(carry_out1), 64'd1);
    out_ready1 = 1'b1;
    stepCycle();
    out_ready1 = 1'b0;
    checkOutput("w1_back_ready", 64'(in_ready1), 64'd1);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      a         = W'($urandom);
      b         = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      abort     = ($urandom_range(0, 15) == 0);
      stepCycle();
    end
    in_valid  = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    repeat (W + 4) stepCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
